// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings and
// the status flag bundle produced by the adder.
package alu_pkg;

  localparam logic [1:0] OP_ADD  = 2'd0;
  localparam logic [1:0] OP_SUB  = 2'd1;
  localparam logic [1:0] OP_ADDC = 2'd2;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
    logic neg;
  } flags_t;

endpackage

// File: rtl/cla_group4.sv
// 4-bit carry-lookahead group: per-bit carries
// plus group propagate/generate for rippling.
module cla_group4 (
  input  logic [3:0] p_i,
  input  logic [3:0] g_i,
  input  logic       c_i,
  output logic [3:0] c_o,
  output logic       pg_o,
  output logic       gg_o
);

  // c_o[n] is the carry into bit n of the group
  assign c_o[0] = c_i;
  assign c_o[1] = g_i[0]
                | (p_i[0] & c_i);
  assign c_o[2] = g_i[1]
                | (p_i[1] & g_i[0])
                | (p_i[1] & p_i[0] & c_i);
  assign c_o[3] = g_i[2]
                | (p_i[2] & g_i[1])
                | (p_i[2] & p_i[1] & g_i[0])
                | (p_i[2] & p_i[1] & p_i[0] & c_i);

  assign pg_o = &p_i;
  assign gg_o = g_i[3]
              | (p_i[3] & g_i[2])
              | (p_i[3] & p_i[2] & g_i[1])
              | (p_i[3] & p_i[2] & p_i[1] & g_i[0]);

endmodule

// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead add/sub, one SEG-bit
// segment resolved per stage, valid/ready handshake.
module pipelined_cla_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int STAGES = WIDTH / SEG;
  localparam int NG     = SEG / 4;

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic             ov_q;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  flags_t           fl;

  assign adv      = !(ov_q && !out_ready);
  assign in_ready = adv;

  always_comb begin
    b_eff = b;
    c_eff = 1'b0;
    unique case (1'b1)
      (op == OP_SUB): begin
        b_eff = ~b;
        c_eff = 1'b1;
      end
      (op == OP_ADDC): c_eff = cin;
      default: ;
    endcase
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    // operand bits not yet consumed at this stage
    localparam int H = WIDTH - k * SEG;

    logic             v_q;
    logic             c_q;
    logic [H-1:0]     a_q;
    logic [H-1:0]     b_q;
    logic [SEG-1:0]   p, g, cv, sum;
    logic [NG:0]      gc;

    assign p     = a_q[SEG-1:0] ^ b_q[SEG-1:0];
    assign g     = a_q[SEG-1:0] & b_q[SEG-1:0];
    assign gc[0] = c_q;

    for (genvar j = 0; j < NG; j++) begin : g_grp
      logic pg, gg;
      cla_group4 u_grp (
        .p_i  (p[4*j +: 4]),
        .g_i  (g[4*j +: 4]),
        .c_i  (gc[j]),
        .c_o  (cv[4*j +: 4]),
        .pg_o (pg),
        .gg_o (gg)
      );
      assign gc[j+1] = gg | (pg & gc[j]);
    end

    assign sum = p ^ cv;

    if (k == 0) begin : g_in
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v_q <= 1'b0;
          a_q <= '0;
          b_q <= '0;
          c_q <= 1'b0;
        end else if (adv) begin
          v_q <= in_valid;
          if (in_valid) begin
            a_q <= a;
            b_q <= b_eff;
            c_q <= c_eff;
          end
        end
      end
    end else begin : g_mid
      logic [k*SEG-1:0] lo_q, lo_d;

      if (k == 1) begin : g_lo1
        assign lo_d = g_st[0].sum;
      end else begin : g_lon
        assign lo_d = {g_st[k-1].sum,
                       g_st[k-1].g_mid.lo_q};
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v_q  <= 1'b0;
          a_q  <= '0;
          b_q  <= '0;
          c_q  <= 1'b0;
          lo_q <= '0;
        end else if (adv) begin
          v_q  <= g_st[k-1].v_q;
          a_q  <= g_st[k-1].a_q[H+SEG-1:SEG];
          b_q  <= g_st[k-1].b_q[H+SEG-1:SEG];
          c_q  <= g_st[k-1].gc[NG];
          lo_q <= lo_d;
        end
      end
    end
  end

  if (STAGES == 1) begin : g_s1
    assign s_d = g_st[0].sum;
  end else begin : g_sn
    assign s_d = {g_st[STAGES-1].sum,
                  g_st[STAGES-1].g_mid.lo_q};
  end

  assign cout_d = g_st[STAGES-1].gc[NG];
  assign ovf_d  = g_st[STAGES-1].cv[SEG-1] ^ cout_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ov_q   <= 1'b0;
      s_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (adv) begin
      ov_q <= g_st[STAGES-1].v_q;
      if (g_st[STAGES-1].v_q) begin
        s_q    <= s_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
      end
    end
  end

  assign fl = '{cout: cout_q,
                ovf:  ovf_q,
                zero: (s_q == '0),
                neg:  s_q[WIDTH-1]};

  assign {cout, ovf, zero, neg} = fl;
  assign out_valid = ov_q;
  assign s         = s_q;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Scoreboard bench: random and directed ops against
// an arithmetic reference model, checked in order.
module tb_pipelined_cla_addsub;
  import alu_pkg::*;

  localparam int W  = 32;
  localparam int SG = 8;
  localparam int ST = W / SG;

  typedef struct packed {
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic         neg;
  } res_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   op = 2'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] s;
  logic         cout, ovf, zero, neg;

  int   checks = 0;
  int   errors = 0;
  int   accepted = 0;
  res_t sb[$];
  res_t mon_e;

  always #5 clk = ~clk;

  pipelined_cla_addsub #(.WIDTH(W), .SEG(SG)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero),
    .neg       (neg)
  );

  function automatic res_t model(
    input logic [1:0]   o,
    input logic [W-1:0] x,
    input logic [W-1:0] y,
    input logic         ci
  );
    res_t         r;
    longint       sx, sy, ssum;
    logic [W:0]   u;
    logic [W-1:0] t;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (o == OP_SUB) begin
      ssum   = sx - sy;
      r.s    = x - y;
      r.cout = (x >= y);
    end else if (o == OP_ADDC) begin
      ssum = sx + sy + longint'(ci);
      u    = {1'b0, x} + {1'b0, y}
           + (W+1)'(ci);
      r.s    = u[W-1:0];
      r.cout = u[W];
    end else begin
      ssum = sx + sy;
      u    = {1'b0, x} + {1'b0, y};
      r.s    = u[W-1:0];
      r.cout = u[W];
    end
    t      = r.s;
    r.ovf  = (ssum != longint'($signed(t)));
    r.zero = (r.s == '0);
    r.neg  = t[W-1];
    return r;
  endfunction

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = '1;
      1:       v = '0;
      2:       v = 32'h7FFF_FFFF;
      3:       v = 32'h8000_0000;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  task automatic chk(
    input string       nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  // stimulus side: record every accepted operand
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", 64'(in_ready),
          64'(!(out_valid && !out_ready)));
      if (in_valid && in_ready) begin
        sb.push_back(model(op, a, b, cin));
        accepted++;
      end
    end
  end

  // monitor side: compare each result leaving
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stale: got s=%h expected none",
                 s);
      end else begin
        mon_e = sb.pop_front();
        chk("result",
            64'({s, cout, ovf, zero, neg}),
            64'(mon_e));
      end
    end
  end

  task automatic run_one(
    input logic [1:0]   o,
    input logic [W-1:0] x,
    input logic [W-1:0] y,
    input logic         ci,
    input logic [W-1:0] es,
    input logic         ec,
    input logic         eo
  );
    @(posedge clk); #1;
    in_valid  = 1'b1;
    op        = o;
    a         = x;
    b         = y;
    cin       = ci;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    cin      = ~ci;
    for (int i = 1; i <= ST; i++) begin
      @(posedge clk); #1;
      chk("latency", 64'(out_valid), 64'(i == ST));
    end
    chk("directed",
        64'({s, cout, ovf, zero, neg}),
        64'({es, ec, eo, es == '0, es[W-1]}));
  endtask

  task automatic chk_reset(input string nm);
    chk(nm,
        64'({out_valid, s, cout, ovf, zero, neg}),
        64'({1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0}));
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int base;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset_state");
    rst = 1'b0;

    run_one(OP_ADD, 32'hFFFF_FFFF, 32'h1, 1'b0,
            32'h0, 1'b1, 1'b0);
    run_one(OP_ADD, 32'h7FFF_FFFF, 32'h1, 1'b0,
            32'h8000_0000, 1'b0, 1'b1);
    run_one(OP_SUB, 32'd5, 32'd7, 1'b0,
            32'hFFFF_FFFE, 1'b0, 1'b0);
    run_one(OP_SUB, 32'd7, 32'd5, 1'b0,
            32'd2, 1'b1, 1'b0);
    run_one(OP_ADDC, 32'hFF, 32'h0, 1'b1,
            32'h100, 1'b0, 1'b0);

    base = accepted;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk); #1;
      if (accepted - base >= 200) break;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      op        = 2'($urandom_range(0, 3));
      a         = pick();
      b         = pick();
      cin       = 1'($urandom_range(0, 1));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("stream_count", 64'(accepted - base), 64'd200);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (sb.size() == 0) break;
    end
    chk("drain", 64'(sb.size()), 64'd0);

    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      op       = 2'($urandom_range(0, 2));
      a        = $urandom;
      b        = $urandom;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst      = 1'b1;
    sb.delete();
    #1;
    chk_reset("reset_in_flight");
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("post_reset_idle", 64'(out_valid), 64'd0);
    end

    run_one(OP_ADD, 32'h1234_5678, 32'h1111_1111,
            1'b0, 32'h2345_6789, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    chk("final_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
